debug_tx_sequencer: RTL

Sequences the post-halt debug dump from the MIPS pipeline to the host over the UART transmitter. When started, it walks the 32 general-purpose registers, then the data memory words, then the PC. Each 32-bit word is serialized LSB-byte-first into the `tx_uart` byte handshake. It sits between the debug unit's main FSM, the register-file/data-memory debug read ports and `tx_uart`, and replaces ad-hoc dump logic inside the debug unit.

---
 rtl/debug_pkg.sv | 31 +++
 rtl/debug_tx_sequencer_handshake.sv | 61 ++++++
 rtl/debug_tx_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: FSM encodings and the default dump
// geometry used by both the debug unit and the transmit sequencer.
package debug_pkg;

    localparam int N_REGISTER_DEF    = 32;
    localparam int N_MEMORY_DATA_DEF = 127;
    localparam int N_BYTES_DEF       = 4;

    typedef enum logic [6:0] {
        ST_IDLE      = 7'b000_0001,
        ST_LOAD      = 7'b000_0010,
        ST_SEND      = 7'b000_0100,
        ST_WAIT_ACK  = 7'b000_1000,
        ST_WAIT_DONE = 7'b001_0000,
        ST_NEXT      = 7'b010_0000,
        ST_FINISH    = 7'b100_0000
    } seq_state_e;

    typedef enum logic [1:0] {
        SEC_REGS = 2'd0,
        SEC_MEM  = 2'd1,
        SEC_PC   = 2'd2
    } section_e;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_ACK  = 2'd1,
        HS_DONE = 2'd2
    } hs_state_e;

endpackage

// File: rtl/debug_tx_sequencer_handshake.sv
// One-byte request/accept/complete handshake with tx_uart. The byte is
// launched on byte_valid_i and byte_accepted_o pulses once the frame is done.
module tx_byte_handshake
    import debug_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              byte_valid_i,
    input  logic [N_BITS-1:0] byte_i,
    input  logic              tx_done_i,
    output logic              byte_accepted_o,
    output logic              tx_start_o,
    output logic [N_BITS-1:0] tx_data_o
);

    hs_state_e         hs_q, hs_d;
    logic [N_BITS-1:0] data_q, data_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            hs_q   <= HS_IDLE;
            data_q <= '0;
        end else begin
            hs_q   <= hs_d;
            data_q <= data_d;
        end
    end

    // tx_start_o depends only on the registered handshake state and the
    // caller's Moore-decoded byte_valid_i, never on tx_done_i.
    always_comb begin
        hs_d            = hs_q;
        data_d          = data_q;
        tx_start_o      = 1'b0;
        byte_accepted_o = 1'b0;
        case (hs_q)
            HS_IDLE: begin
                if (byte_valid_i) begin
                    tx_start_o = 1'b1;
                    data_d     = byte_i;
                    hs_d       = HS_ACK;
                end
            end
            HS_ACK: begin
                if (!tx_done_i) hs_d = HS_DONE;
            end
            HS_DONE: begin
                if (tx_done_i) begin
                    byte_accepted_o = 1'b1;
                    hs_d            = HS_IDLE;
                end
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    assign tx_data_o = (hs_q == HS_IDLE) ? byte_i : data_q;

endmodule

// File: rtl/debug_tx_sequencer.sv
// Post-halt debug dump: registers, then data memory, then PC, each word sent
// LSB byte first through the tx_uart byte handshake.
module debug_tx_sequencer
    import debug_pkg::*;
#(
    parameter int NB_DATA       = 32,
    parameter int N_BITS        = 8,
    parameter int N_BYTES       = N_BYTES_DEF,
    parameter int N_REGISTER    = N_REGISTER_DEF,
    parameter int N_MEMORY_DATA = N_MEMORY_DATA_DEF,
    parameter int NB_REG        = 5,
    parameter int NB_ADDR       = 7,
    parameter int NB_PC         = 7
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic [NB_REG-1:0]  reg_addr_o,
    input  logic [NB_DATA-1:0] reg_data_i,
    output logic [NB_ADDR-1:0] mem_addr_o,
    input  logic [NB_DATA-1:0] mem_data_i,
    input  logic [NB_PC-1:0]   pc_i,
    output logic               sel_debug_o,
    output logic [N_BITS-1:0]  tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int NB_CNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    seq_state_e         state_q, state_d;
    section_e           sec_q, sec_d;
    logic [NB_REG-1:0]  reg_addr_q, reg_addr_d;
    logic [NB_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [NB_CNT-1:0]  byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               last_word_q, last_word_d;
    logic               abort_q, abort_d;
    logic               abort_any;
    logic               last_byte;
    logic               byte_valid;
    logic               byte_accepted;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            sec_q       <= SEC_REGS;
            reg_addr_q  <= '0;
            mem_addr_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            last_word_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            reg_addr_q  <= reg_addr_d;
            mem_addr_q  <= mem_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            last_word_q <= last_word_d;
            abort_q     <= abort_d;
        end
    end

    assign abort_any = abort_q | abort_i;
    assign last_byte = (sec_q == SEC_PC) ? (byte_cnt_q == '0)
                                         : (byte_cnt_q == NB_CNT'(N_BYTES - 1));

    // The address advance happens on the way into NEXT so the synchronous
    // debug read ports already present the new word by the LOAD cycle.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        last_word_d = last_word_q;
        abort_d     = (state_q == ST_IDLE) ? 1'b0 : abort_any;
        case (state_q)
            ST_IDLE: begin
                sec_d       = SEC_REGS;
                reg_addr_d  = '0;
                mem_addr_d  = '0;
                byte_cnt_d  = '0;
                last_word_d = 1'b0;
                if (start_i && !abort_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort_any) begin
                    state_d = ST_IDLE;
                end else begin
                    case (sec_q)
                        SEC_REGS: shift_d = reg_data_i;
                        SEC_MEM:  shift_d = mem_data_i;
                        default:  shift_d = {{(NB_DATA - NB_PC){1'b0}}, pc_i};
                    endcase
                    state_d = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!tx_done_i) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (byte_accepted) begin
                    if (abort_any) begin
                        state_d = ST_IDLE;
                    end else if (!last_byte) begin
                        shift_d    = shift_q >> N_BITS;
                        byte_cnt_d = byte_cnt_q + NB_CNT'(1);
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_NEXT;
                        case (sec_q)
                            SEC_REGS: begin
                                if (reg_addr_q == NB_REG'(N_REGISTER - 1)) begin
                                    sec_d      = SEC_MEM;
                                    mem_addr_d = '0;
                                end else begin
                                    reg_addr_d = reg_addr_q + NB_REG'(1);
                                end
                            end
                            SEC_MEM: begin
                                if (mem_addr_q == NB_ADDR'(N_MEMORY_DATA - 1))
                                    sec_d = SEC_PC;
                                else
                                    mem_addr_d = mem_addr_q + NB_ADDR'(1);
                            end
                            default: last_word_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_NEXT: begin
                byte_cnt_d = '0;
                if (abort_any)        state_d = ST_IDLE;
                else if (last_word_q) state_d = ST_FINISH;
                else                  state_d = ST_LOAD;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign byte_valid  = (state_q == ST_SEND);
    assign busy_o      = (state_q != ST_IDLE);
    assign sel_debug_o = busy_o;
    assign done_o      = (state_q == ST_FINISH) && !abort_q;
    assign reg_addr_o  = reg_addr_q;
    assign mem_addr_o  = mem_addr_q;

    tx_byte_handshake #(
        .N_BITS (N_BITS)
    ) u_handshake (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .byte_valid_i    (byte_valid),
        .byte_i          (shift_q[N_BITS-1:0]),
        .tx_done_i       (tx_done_i),
        .byte_accepted_o (byte_accepted),
        .tx_start_o      (tx_start_o),
        .tx_data_o       (tx_data_o)
    );

endmodule
